// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared definitions for the iterative ALU.
//   - opcode constants carried on the 8-bit Selector input
//   - bit positions inside the 8-bit Flags output
//   - control FSM state encoding (also driven out on the debug port)
//   - multiply/divide engine operation encoding
//   - parity helper used for the P flag
package alu_iter_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;
    localparam logic [7:0] OP_AND  = 8'h05;
    localparam logic [7:0] OP_OR   = 8'h06;
    localparam logic [7:0] OP_XOR  = 8'h07;
    localparam logic [7:0] OP_NOT  = 8'h08;
    localparam logic [7:0] OP_NAND = 8'h09;
    localparam logic [7:0] OP_NOR  = 8'h0A;
    localparam logic [7:0] OP_XNOR = 8'h0B;
    localparam logic [7:0] OP_SHL  = 8'h0C;
    localparam logic [7:0] OP_SHR  = 8'h0D;
    localparam logic [7:0] OP_CMP  = 8'h0E;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_S   = 2;
    localparam int FLAG_P   = 3;
    localparam int FLAG_DZ  = 4;
    localparam int FLAG_ILL = 5;
    localparam int FLAG_O   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

    // 1 when the byte holds an even number of ones.
    function automatic logic even_ones8(input logic [7:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative unsigned multiply / restoring divide engine,
// one bit per cycle, WIDTH steps per operation.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts a run)
//   start_i       load operands and begin (only pulsed while idle)
//   op_i          MD_MUL or MD_DIV
//   a_i, b_i      operands (multiplier/multiplicand, dividend/divisor)
//   done_o        high during the cycle whose edge performs the last step
//   lo_o, hi_o    result of that step: product low/high, or quotient/remainder
// lo_o/hi_o are the next-state values of the working registers, so the
// consumer must register them on the edge where done_o is high.
module alu_iter_muldiv
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    md_op_e           op_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // MUL: {hi,lo} is the partial product with the multiplier shifting out
    // of lo. DIV: lo holds the dividend shifting into hi (the remainder),
    // quotient bits enter lo from the bottom.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        // remainder < divisor, so the shifted value is below 2*divisor and
        // the MSB of the difference is its sign.
        rem_diff = rem_sh - {1'b0, b_q};
        lo_d     = lo_q;
        hi_d     = hi_q;
        if (op_q == MD_MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            op_q  <= MD_MUL;
            lo_q  <= '0;
            hi_q  <= '0;
            b_q   <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CW'(WIDTH);
            op_q  <= op_i;
            lo_q  <= a_i;
            hi_q  <= '0;
            b_q   <= b_i;
        end else if (run_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU. Single-cycle ops complete in one cycle; MUL/DIV
// iterate one bit per cycle in alu_iter_muldiv.
// Build option: define ALU_ITER_MULDIV_EN to include MUL/DIV; without it
// those opcodes are reported as illegal and the BUSY state is unreachable.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   A, B                  WIDTH-bit operands
//   Selector              8-bit opcode (see alu_iter_pkg)
//   in_valid / in_ready   operand handshake
//   out_valid / out_ready result handshake
//   X                     result (low half)
//   X_hi                  product high half / remainder / DIV-by-0 dividend
//   Flags                 {0, O, ILL, DZ, P, S, C, Z}
//   dbg_state_o           current control state
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE (and not while rst is high); out_valid
// is 1 only in DONE, where X/X_hi/Flags stay frozen until out_ready.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       Selector,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_hi,
    output logic [7:0]       Flags,
    output state_e           dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] xhi_q, xhi_d;
    logic [7:0]       flags_q, flags_d;
    logic             load;
    logic             accept;
    logic             eng_done;

    // single-cycle datapath results
    logic [WIDTH-1:0] s_lo, s_hi;
    logic             s_c, s_o, s_dz, s_ill, s_cmp, go_iter;
    logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
    logic [SHW-1:0]   sh_amt;
    logic             add_ovf, sub_ovf;

    // selected result feeding the output registers
    logic             r_c, r_o, r_dz, r_ill, r_cmp, r_eq;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s_lo    = '0;
        s_hi    = '0;
        s_c     = 1'b0;
        s_o     = 1'b0;
        s_dz    = 1'b0;
        s_ill   = 1'b0;
        s_cmp   = 1'b0;
        go_iter = 1'b0;
        sh_amt  = B[SHW-1:0];
        sum_w   = {1'b0, A} + {1'b0, B};
        diff_w  = {1'b0, A} - {1'b0, B};
        // extra bit on the shifted-out side catches the last bit lost
        shl_w   = {1'b0, A} << sh_amt;
        shr_w   = {A, 1'b0} >> sh_amt;
        add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
        sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
        case (Selector)
            OP_ADD:  begin s_lo = sum_w[WIDTH-1:0];  s_c = sum_w[WIDTH];  s_o = add_ovf; end
            OP_SUB:  begin s_lo = diff_w[WIDTH-1:0]; s_c = diff_w[WIDTH]; s_o = sub_ovf; end
            OP_AND:  s_lo = A & B;
            OP_OR:   s_lo = A | B;
            OP_XOR:  s_lo = A ^ B;
            OP_NOT:  s_lo = ~A;
            OP_NAND: s_lo = ~(A & B);
            OP_NOR:  s_lo = ~(A | B);
            OP_XNOR: s_lo = ~(A ^ B);
            OP_SHL:  begin s_lo = shl_w[WIDTH-1:0]; s_c = shl_w[WIDTH]; end
            OP_SHR:  begin s_lo = shr_w[WIDTH:1];   s_c = shr_w[0];     end
            OP_CMP: begin
                s_lo[0] = (A == B);
                s_lo[1] = (A > B);
                s_lo[2] = (A < B);
                s_c     = diff_w[WIDTH];
                s_o     = sub_ovf;
                s_cmp   = 1'b1;
            end
`ifdef ALU_ITER_MULDIV_EN
            OP_MUL:  go_iter = 1'b1;
            OP_DIV: begin
                // divide by zero skips the engine and answers at once
                if (B == '0) begin
                    s_lo = '1;
                    s_hi = A;
                    s_dz = 1'b1;
                end else begin
                    go_iter = 1'b1;
                end
            end
`endif
            default: s_ill = 1'b1;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    logic [WIDTH-1:0] eng_lo, eng_hi;
    logic             eng_start;
    md_op_e           op_q, op_d;

    assign eng_start = accept && go_iter;
    assign op_d      = (Selector == OP_DIV) ? MD_DIV : MD_MUL;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= MD_MUL;
        end else if (eng_start) begin
            op_q <= op_d;
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (eng_start),
        .op_i    (op_d),
        .a_i     (A),
        .b_i     (B),
        .done_o  (eng_done),
        .lo_o    (eng_lo),
        .hi_o    (eng_hi)
    );
`else
    assign eng_done = 1'b0;
`endif

    // Result/flag capture: on accept of a single-cycle op, or on the last
    // engine step. Flags always describe the value being loaded into X.
    always_comb begin
        load  = 1'b0;
        x_d   = x_q;
        xhi_d = xhi_q;
        r_c   = 1'b0;
        r_o   = 1'b0;
        r_dz  = 1'b0;
        r_ill = 1'b0;
        r_cmp = 1'b0;
        r_eq  = 1'b0;
        if (accept && !go_iter) begin
            load  = 1'b1;
            x_d   = s_lo;
            xhi_d = s_hi;
            r_c   = s_c;
            r_o   = s_o;
            r_dz  = s_dz;
            r_ill = s_ill;
            r_cmp = s_cmp;
            r_eq  = s_lo[0];
        end
`ifdef ALU_ITER_MULDIV_EN
        else if ((state_q == ST_BUSY) && eng_done) begin
            load  = 1'b1;
            x_d   = eng_lo;
            xhi_d = eng_hi;
            r_c   = (op_q == MD_MUL) && (eng_hi != '0);
            r_o   = r_c;
        end
`endif
        flags_d           = '0;
        // illegal ops report ILL alone; CMP's Z is equality, not X==0
        flags_d[FLAG_Z]   = !r_ill && (r_cmp ? r_eq : (x_d == '0));
        flags_d[FLAG_C]   = r_c;
        flags_d[FLAG_S]   = !r_ill && x_d[WIDTH-1];
        flags_d[FLAG_P]   = !r_ill && even_ones8(x_d[7:0]);
        flags_d[FLAG_DZ]  = r_dz;
        flags_d[FLAG_ILL] = r_ill;
        flags_d[FLAG_O]   = r_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            xhi_q   <= '0;
            flags_q <= '0;
        end else if (load) begin
            x_q     <= x_d;
            xhi_q   <= xhi_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = go_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (eng_done)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign out_valid   = (state_q == ST_DONE);
    assign X           = x_q;
    assign X_hi        = xhi_q;
    assign Flags       = flags_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed-vector bench for alu_iter (WIDTH=8). Inputs are
// driven at the falling edge, outputs sampled 1 time unit after the rising
// edge. MUL/DIV expectations follow the ALU_ITER_MULDIV_EN build option.
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [7:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] x;
        logic [W-1:0] hi;
        logic [7:0]   fl;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [7:0]   Selector = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] X;
    logic [W-1:0] X_hi;
    logic [7:0]   Flags;
    state_e       dbg_state;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic ready_in_wait;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .Selector    (Selector),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .X           (X),
        .X_hi        (X_hi),
        .Flags       (Flags),
        .dbg_state_o (dbg_state)
    );

    // Driver: issue one op, measure latency (1 = out_valid in the cycle
    // after accept), capture the result, then consume it with out_ready.
    task automatic run_op(input logic [7:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] x, output logic [W-1:0] hi,
                          output logic [7:0] fl, output int lat);
        @(negedge clk);
        Selector = sel;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_idle sel=%h: got %b exp 1", sel, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        lat           = 1;
        ready_in_wait = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) ready_in_wait = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        x  = X;
        hi = X_hi;
        fl = Flags;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (X !== 8'h00)        begin n_fail++; $display("FAIL rst_X: got %h exp 00", X); end
        n_checks++; if (X_hi !== 8'h00)     begin n_fail++; $display("FAIL rst_X_hi: got %h exp 00", X_hi); end
        n_checks++; if (Flags !== 8'h00)    begin n_fail++; $display("FAIL rst_Flags: got %h exp 00", Flags); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d exp IDLE", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_rst_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_arith();
        vec_t v[7];
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
        v[0] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h0B, 1};
        v[1] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h44, 1};
        v[2] = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 8'h00, 8'h06, 1};
        v[3] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 8'h40, 1};
        v[4] = '{OP_CMP, 8'h05, 8'h05, 8'h01, 8'h00, 8'h01, 1};
        v[5] = '{OP_CMP, 8'h03, 8'h09, 8'h04, 8'h00, 8'h02, 1};
        v[6] = '{OP_CMP, 8'h09, 8'h03, 8'h02, 8'h00, 8'h00, 1};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].sel, v[i].a, v[i].b, x, hi, fl, lat);
            n_checks++; if (x !== v[i].x)     begin n_fail++; $display("FAIL arith[%0d] X: got %h exp %h", i, x, v[i].x); end
            n_checks++; if (hi !== v[i].hi)   begin n_fail++; $display("FAIL arith[%0d] X_hi: got %h exp %h", i, hi, v[i].hi); end
            n_checks++; if (fl !== v[i].fl)   begin n_fail++; $display("FAIL arith[%0d] Flags: got %h exp %h", i, fl, v[i].fl); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL arith[%0d] latency: got %0d exp %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_logic_shift();
        vec_t v[8];
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
        v[0] = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 8'h08, 1};
        v[1] = '{OP_NOT,  8'h0F, 8'h00, 8'hF0, 8'h00, 8'h0C, 1};
        v[2] = '{OP_NOR,  8'h00, 8'h00, 8'hFF, 8'h00, 8'h0C, 1};
        v[3] = '{OP_XNOR, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h09, 1};
        v[4] = '{OP_SHL,  8'h81, 8'h01, 8'h02, 8'h00, 8'h02, 1};
        v[5] = '{OP_SHR,  8'h81, 8'h01, 8'h40, 8'h00, 8'h02, 1};
        v[6] = '{OP_SHL,  8'h81, 8'h00, 8'h81, 8'h00, 8'h0C, 1};
        v[7] = '{OP_SHR,  8'h81, 8'h07, 8'h01, 8'h00, 8'h00, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].sel, v[i].a, v[i].b, x, hi, fl, lat);
            n_checks++; if (x !== v[i].x)     begin n_fail++; $display("FAIL logic[%0d] X: got %h exp %h", i, x, v[i].x); end
            n_checks++; if (hi !== v[i].hi)   begin n_fail++; $display("FAIL logic[%0d] X_hi: got %h exp %h", i, hi, v[i].hi); end
            n_checks++; if (fl !== v[i].fl)   begin n_fail++; $display("FAIL logic[%0d] Flags: got %h exp %h", i, fl, v[i].fl); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL logic[%0d] latency: got %0d exp %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_muldiv();
        vec_t v[6];
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
`ifdef ALU_ITER_MULDIV_EN
        v[0] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 8'h4B, 9};
        v[1] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h42, 9};
        v[2] = '{OP_DIV, 8'hC8, 8'h07, 8'h1C, 8'h04, 8'h00, 9};
        v[3] = '{OP_DIV, 8'hFF, 8'h10, 8'h0F, 8'h0F, 8'h08, 9};
        v[4] = '{OP_DIV, 8'h05, 8'h09, 8'h00, 8'h05, 8'h09, 9};
        v[5] = '{OP_DIV, 8'h55, 8'h00, 8'hFF, 8'h55, 8'h1C, 1};
`else
        v[0] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h00, 8'h20, 1};
        v[1] = '{OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h20, 1};
        v[2] = '{OP_DIV, 8'hC8, 8'h07, 8'h00, 8'h00, 8'h20, 1};
        v[3] = '{OP_DIV, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h20, 1};
        v[4] = '{OP_DIV, 8'h05, 8'h09, 8'h00, 8'h00, 8'h20, 1};
        v[5] = '{OP_DIV, 8'h55, 8'h00, 8'h00, 8'h00, 8'h20, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].sel, v[i].a, v[i].b, x, hi, fl, lat);
            n_checks++; if (x !== v[i].x)     begin n_fail++; $display("FAIL muldiv[%0d] X: got %h exp %h", i, x, v[i].x); end
            n_checks++; if (hi !== v[i].hi)   begin n_fail++; $display("FAIL muldiv[%0d] X_hi: got %h exp %h", i, hi, v[i].hi); end
            n_checks++; if (fl !== v[i].fl)   begin n_fail++; $display("FAIL muldiv[%0d] Flags: got %h exp %h", i, fl, v[i].fl); end
            n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL muldiv[%0d] latency: got %0d exp %0d", i, lat, v[i].lat); end
            n_checks++; if (ready_in_wait !== 1'b0) begin n_fail++; $display("FAIL muldiv[%0d] in_ready_while_busy: got 1 exp 0", i); end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops[3];
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
        ops[0] = 8'h3F;
        ops[1] = 8'h00;
        ops[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 8'hA5, 8'h5A, x, hi, fl, lat);
            n_checks++; if (x !== 8'h00)  begin n_fail++; $display("FAIL ill[%0d] X: got %h exp 00", i, x); end
            n_checks++; if (hi !== 8'h00) begin n_fail++; $display("FAIL ill[%0d] X_hi: got %h exp 00", i, hi); end
            n_checks++; if (fl !== 8'h20) begin n_fail++; $display("FAIL ill[%0d] Flags: got %h exp 20", i, fl); end
            n_checks++; if (lat !== 1)    begin n_fail++; $display("FAIL ill[%0d] latency: got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
        logic seen;
        @(negedge clk);
        Selector = OP_ADD; A = 8'h12; B = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_lat1: got %b exp 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Selector = OP_SUB; A = 8'h99; B = 8'h11; in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp[%0d] out_valid: got %b exp 1", i, out_valid); end
            n_checks++; if (X !== 8'h46)        begin n_fail++; $display("FAIL bp[%0d] X: got %h exp 46", i, X); end
            n_checks++; if (Flags !== 8'h00)    begin n_fail++; $display("FAIL bp[%0d] Flags: got %h exp 00", i, Flags); end
            n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp[%0d] in_ready: got %b exp 0", i, in_ready); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release out_valid: got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release in_ready: got %b exp 1", in_ready); end
        n_checks++; if (X !== 8'h46)        begin n_fail++; $display("FAIL bp_release X: got %h exp 46", X); end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_op produced out_valid: got 1 exp 0"); end
        run_op(OP_ADD, 8'h20, 8'h22, x, hi, fl, lat);
        n_checks++; if (x !== 8'h42)  begin n_fail++; $display("FAIL bp_next X: got %h exp 42", x); end
        n_checks++; if (fl !== 8'h08) begin n_fail++; $display("FAIL bp_next Flags: got %h exp 08", fl); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] x, hi;
        logic [7:0] fl;
        int lat;
        logic seen;
        @(negedge clk);
        Selector = OP_MUL; A = 8'h10; B = 8'h10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_ITER_MULDIV_EN
        n_checks++; if (dbg_state !== ST_BUSY) begin n_fail++; $display("FAIL abort_pre_state: got %0d exp BUSY", dbg_state); end
`else
        n_checks++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL abort_pre_state: got %0d exp DONE", dbg_state); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL abort_rst out_valid: got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL abort_rst in_ready: got %b exp 0", in_ready); end
        n_checks++; if (X !== 8'h00)           begin n_fail++; $display("FAIL abort_rst X: got %h exp 00", X); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_rst state: got %0d exp IDLE", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_after in_ready: got %b exp 1", in_ready); end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_result_leaked: got out_valid exp none"); end
        run_op(OP_ADD, 8'h01, 8'h02, x, hi, fl, lat);
        n_checks++; if (x !== 8'h03)  begin n_fail++; $display("FAIL abort_next X: got %h exp 03", x); end
        n_checks++; if (fl !== 8'h08) begin n_fail++; $display("FAIL abort_next Flags: got %h exp 08", fl); end
        n_checks++; if (lat !== 1)    begin n_fail++; $display("FAIL abort_next latency: got %0d exp 1", lat); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_muldiv();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 8..32).
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports A, B  in  WIDTH  operands.
REQ-005 SHALL have port Selector  in  8  opcode: 01 ADD, 02 SUB, 03 MUL, 04 DIV, 05 AND, 06 OR, 07 XOR, 08 NOT(A), 09 NAND, 0A NOR, 0B XNOR, 0C SHL, 0D SHR, 0E CMP; others illegal.
REQ-006 SHALL have ports in_valid in 1 / in_ready out 1  operand handshake.
REQ-007 SHALL have ports out_valid out 1 / out_ready in 1  result handshake.
REQ-008 SHALL have ports X out WIDTH (result low), X_hi out WIDTH (product high half / remainder, else 0), Flags out 8.

Function
REQ-009 Flags bits SHALL be: 0 Z, 1 C, 2 S, 3 P, 4 DZ, 5 ILL, 6 O, 7 always 0.
REQ-010 Flags SHALL derive from the new result of the same op: Z = X==0; S = X[WIDTH-1]; P = 1 when X[7:0] has even number of ones.
REQ-011 Operation accepted on cycle with in_valid && in_ready; A, B, Selector captured then.
REQ-012 States: IDLE (in_ready=1), BUSY (MUL/DIV iterating), DONE (out_valid=1); in_ready SHALL be 1 only in IDLE.
REQ-013 Single-cycle ops: IDLE->DONE; out_valid 1 cycle after accept.
REQ-014 MUL: unsigned shift-add, one bit/cycle; IDLE->BUSY->DONE; out_valid WIDTH+1 cycles after accept; {X_hi,X} = A*B; C=O=(X_hi!=0).
REQ-015 DIV: unsigned restoring, same latency as MUL; X=quotient, X_hi=remainder; C=O=0.
REQ-016 DIV with B==0: 1-cycle latency, X=all ones, X_hi=A, DZ=1.
REQ-017 ADD: C=carry out; O=signed overflow. SUB: X=A-B, C=borrow (A<B unsigned), O=signed overflow.
REQ-018 Logic ops: C=O=0. SHL/SHR: amount B[$clog2(WIDTH)-1:0]; C = last bit shifted out, 0 for amount 0; O=0.
REQ-019 CMP (unsigned): X[0]=eq, X[1]=A>B, X[2]=A<B, other bits 0; C, O as SUB; Z=eq.
REQ-020 Illegal opcode: 1-cycle, X=X_hi=0, ILL=1, other flags 0.
REQ-021 DONE SHALL hold X, X_hi, Flags, out_valid stable until out_ready=1, then IDLE next cycle.
REQ-022 in_valid in non-IDLE states SHALL be ignored (no capture).

Reset
REQ-023 While rst=1 at a clock edge: state IDLE, X=X_hi=0, Flags=0, out_valid=0, in_ready=0 during the rst cycle, in_ready=1 the first cycle after.
REQ-024 rst during BUSY or DONE SHALL abort the operation; no out_valid for it.

Configuration
REQ-025 Macro ALU_ITER_MULDIV_EN defined: MUL/DIV per REQ-014..016.
REQ-026 Macro undefined: MUL/DIV treated as illegal (REQ-020); no iterative engine, BUSY unreachable.

Structure
REQ-027 Package alu_iter_pkg SHALL hold opcode constants, flag bit indices, state encoding.
REQ-028 Sub-module alu_iter_muldiv SHALL hold the iterative multiply/divide engine (start, done, op, A, B, lo, hi), instantiated only under ALU_ITER_MULDIV_EN.

Verification (WIDTH=8, macro defined)
REQ-029 ADD FF+01 -> X=00, Flags Z=1 C=1 P=1 O=0; ADD 7F+01 -> X=80, S=1 O=1 P=0; out_valid 1 cycle after accept.
REQ-030 MUL 10*10 -> X=00, X_hi=01, C=O=1, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
REQ-031 DIV C8/07 -> X=1C, X_hi=04; DIV 55/00 -> X=FF, X_hi=55, DZ=1, 1-cycle latency.
REQ-032 SUB 03-05 -> X=FE, C=1, S=1; CMP 05,05 -> X=01, Z=1; SHL 81 by 1 -> X=02, C=1; Selector=3F -> ILL=1, X=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles after result -> X/Flags stable, out_valid=1, in_ready=0; new in_valid ignored; accepted after out_ready.
REQ-034 rst asserted 4 cycles into MUL -> out_valid never rises for it; next cycle after rst in_ready=1, new ADD completes normally.
